snn_rate_coded_io: RTL and testbench

Parametrised input-encoder / output-readout front end for spiking networks built from `spiking_neuron_2in` instances. It generalises the fixed 2-input XOR wrapper to N_IN rate-coded input channels and N_OUT readout neurons. It adds first-spike winner selection with latency reporting, a programmable timeout, and address-windowed configuration so its commands do not collide with neuron commands on the shared `addr/cmd/cmd_arg` bus. The network neurons sit between `spike_to_net` and `spike_from_net`.

---
 rtl/snn_rate_coded_io.sv | 174 +++++++++++++++++
 tb/tb_snn_rate_coded_io.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/snn_rate_coded_io.sv
// snn_rate_coded_io
//   Rate-coded input encoder and first-spike readout that sits around a
//   network of spiking_neuron_2in instances. It shares the neurons'
//   addr/cmd/cmd_arg bus, and owns the address window starting at IO_ADDR_BASE.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   addr, cmd, cmd_arg  shared command bus
//   in                  logical input vector, gated onto spike_to_net by the encoder
//   spike_to_net        registered input spikes to the first neuron layer
//   spike_from_net      readout neuron spikes
//   done/valid          decision made / made by spike (1) or by timeout (0)
//   winner/latency      lowest-index spiking readout neuron / step of decision
//
// Readout states
//   state    | meaning
//   S_ACTIVE | waiting for a readout spike or the timeout
//   S_DONE   | decision latched, readout frozen until CLEAR or reset
module snn_rate_coded_io #(
   parameter int N_IN         = 4,
   parameter int N_OUT        = 2,
   parameter int INT_WIDTH    = 4,
   parameter int FLOAT_WIDTH  = 2*INT_WIDTH,
   parameter int ADDR_WIDTH   = 4,
   parameter int CMD_WIDTH    = 3,
   parameter int IO_ADDR_BASE = 8,
   parameter int MAX_TIME     = 35,
   parameter int TIME_WIDTH   = 8,
   localparam int WIN_WIDTH   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [CMD_WIDTH-1:0]   cmd,
   input  logic [FLOAT_WIDTH-1:0] cmd_arg,
   input  logic [N_IN-1:0]        in,
   output logic [N_IN-1:0]        spike_to_net,
   input  logic [N_OUT-1:0]       spike_from_net,
   output logic                   done,
   output logic                   valid,
   output logic [WIN_WIDTH-1:0]   winner,
   output logic [TIME_WIDTH-1:0]  latency
);

   localparam logic [CMD_WIDTH-1:0] CMD_RUN         = '0;
   localparam logic [CMD_WIDTH-1:0] CMD_CLEAR       = CMD_WIDTH'((1 << CMD_WIDTH) - 3);
   localparam logic [CMD_WIDTH-1:0] CMD_SET_LEN     = CMD_WIDTH'((1 << CMD_WIDTH) - 4);
   localparam logic [CMD_WIDTH-1:0] CMD_SET_FREQ    = CMD_WIDTH'((1 << CMD_WIDTH) - 5);
   localparam logic [CMD_WIDTH-1:0] CMD_SET_TIMEOUT = CMD_WIDTH'((1 << CMD_WIDTH) - 6);

   localparam logic [ADDR_WIDTH-1:0]  BASE = ADDR_WIDTH'(IO_ADDR_BASE);
   localparam logic [FLOAT_WIDTH:0]   ONE  = (FLOAT_WIDTH+1)'(1 << INT_WIDTH);
   localparam logic [TIME_WIDTH-1:0]  TIMEOUT_RST = TIME_WIDTH'(MAX_TIME);

   typedef enum logic {S_ACTIVE, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic                    valid_d;
   logic [WIN_WIDTH-1:0]    winner_d, first_idx;
   logic [TIME_WIDTH-1:0]   latency_d, t_q, t_d;

   logic [FLOAT_WIDTH-1:0]  freq [N_IN];
   logic [FLOAT_WIDTH:0]    acc  [N_IN];
   logic [INT_WIDTH-1:0]    len, remaining;
   logic [TIME_WIDTH-1:0]   timeout;

   logic                    in_window, ch_zero, ch_in_range;
   logic [ADDR_WIDTH-1:0]   ch;

   assign in_window   = (addr >= BASE);
   assign ch          = addr - BASE;
   assign ch_zero     = in_window && (ch == '0);
   assign ch_in_range = in_window && (32'(ch) < 32'(N_IN));
   assign done        = (state_q == S_DONE);

   // Configuration registers and encoder
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         freq         <= '{default: '0};
         acc          <= '{default: ONE};
         len          <= INT_WIDTH'(1);
         remaining    <= INT_WIDTH'(1);
         timeout      <= TIMEOUT_RST;
         spike_to_net <= '0;
      end else begin
         case (cmd)
            CMD_RUN: begin
               if (!done && remaining != '0) begin
                  remaining <= remaining - INT_WIDTH'(1);
                  for (int i = 0; i < N_IN; i++) begin
                     if (acc[i] >= ONE) begin
                        // keep only the fractional part, then add this step's rate
                        spike_to_net[i] <= in[i];
                        acc[i] <= (FLOAT_WIDTH+1)'(acc[i][INT_WIDTH-1:0])
                                + (FLOAT_WIDTH+1)'(freq[i]);
                     end else begin
                        spike_to_net[i] <= 1'b0;
                        acc[i] <= acc[i] + (FLOAT_WIDTH+1)'(freq[i]);
                     end
                  end
               end else begin
                  spike_to_net <= '0;
               end
            end
            CMD_CLEAR: begin
               acc          <= '{default: ONE};
               remaining    <= len;
               spike_to_net <= '0;
            end
            CMD_SET_LEN: if (ch_zero) len <= cmd_arg[INT_WIDTH-1:0];
            CMD_SET_FREQ: begin
               for (int i = 0; i < N_IN; i++)
                  if (ch_in_range && 32'(ch) == 32'(i)) freq[i] <= cmd_arg;
            end
            CMD_SET_TIMEOUT: if (ch_zero) timeout <= TIME_WIDTH'(cmd_arg);
            default: ;
         endcase
      end
   end

   always_comb begin
      first_idx = '0;
      for (int i = N_OUT-1; i >= 0; i--)
         if (spike_from_net[i]) first_idx = WIN_WIDTH'(i);
   end

   // Readout state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_ACTIVE;
         valid   <= 1'b0;
         winner  <= '0;
         latency <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         valid   <= valid_d;
         winner  <= winner_d;
         latency <= latency_d;
         t_q     <= t_d;
      end
   end

   // Readout next state; a spike takes priority over the timeout on the same step
   always_comb begin
      state_d   = state_q;
      valid_d   = valid;
      winner_d  = winner;
      latency_d = latency;
      t_d       = t_q;
      if (cmd == CMD_CLEAR) begin
         state_d   = S_ACTIVE;
         valid_d   = 1'b0;
         winner_d  = '0;
         latency_d = '0;
         t_d       = '0;
      end else if (cmd == CMD_RUN && state_q == S_ACTIVE) begin
         if (|spike_from_net) begin
            state_d   = S_DONE;
            valid_d   = 1'b1;
            winner_d  = first_idx;
            latency_d = t_q;
         end else if (t_q >= timeout) begin
            state_d   = S_DONE;
            valid_d   = 1'b0;
            winner_d  = '0;
            latency_d = t_q;
         end else if (t_q != '1) begin
            t_d = t_q + TIME_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_snn_rate_coded_io.sv
module tb_snn_rate_coded_io;

   localparam logic [2:0] RUN = 3'd0, CLR = 3'd5, SLEN = 3'd4, SFREQ = 3'd3, STO = 3'd2, IDLE = 3'd1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] addr = '0;
   logic [2:0] cmd = IDLE;
   logic [7:0] cmd_arg = '0;
   logic [3:0] in = '0;
   logic [3:0] spike_to_net;
   logic [2:0] spike_from_net = '0;
   logic       done, valid;
   logic [1:0] winner;
   logic [7:0] latency;

   snn_rate_coded_io #(.N_IN(4), .N_OUT(3)) dut (
      .clk(clk), .rst(rst), .addr(addr), .cmd(cmd), .cmd_arg(cmd_arg), .in(in),
      .spike_to_net(spike_to_net), .spike_from_net(spike_from_net),
      .done(done), .valid(valid), .winner(winner), .latency(latency)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] sp;
      logic       d;
      logic       v;
      logic [1:0] w;
      logic [7:0] lat;
   } exp_t;

   exp_t exp_q [$];
   int   checks = 0;
   int   failures = 0;
   event snap_ev;

   task automatic compare_out();
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_output: got sp=%b done=%b valid=%b winner=%0d latency=%0d, no expectation queued",
                  spike_to_net, done, valid, winner, latency);
         return;
      end
      e = exp_q.pop_front();
      if (spike_to_net !== e.sp || done !== e.d || valid !== e.v || winner !== e.w || latency !== e.lat) begin
         failures++;
         $display("FAIL %s: got sp=%b done=%b valid=%b winner=%0d latency=%0d, want sp=%b done=%b valid=%b winner=%0d latency=%0d",
                  e.tag, spike_to_net, done, valid, winner, latency, e.sp, e.d, e.v, e.w, e.lat);
      end
   endtask

   // Monitor: the DUT presents a result after every RUN edge, and on demand during reset
   always @(posedge clk) begin
      if (rst && cmd == RUN) begin
         #1;
         compare_out();
      end
   end

   always begin
      @(snap_ev);
      compare_out();
   end

   task automatic expect_out(input string tag, input logic [3:0] sp, input logic d, input logic v,
                             input logic [1:0] w, input logic [7:0] lat);
      exp_t e;
      e.tag = tag; e.sp = sp; e.d = d; e.v = v; e.w = w; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic do_cmd(input logic [3:0] a, input logic [2:0] c, input logic [7:0] arg);
      @(negedge clk);
      addr = a; cmd = c; cmd_arg = arg;
      @(negedge clk);
      cmd = IDLE; addr = '0; cmd_arg = '0;
   endtask

   task automatic run(input string tag, input logic [2:0] sfn, input logic [3:0] sp, input logic d,
                      input logic v, input logic [1:0] w, input logic [7:0] lat);
      expect_out(tag, sp, d, v, w, lat);
      @(negedge clk);
      addr = '0; cmd = RUN; spike_from_net = sfn;
      @(negedge clk);
      cmd = IDLE; spike_from_net = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat2 [6];
      logic [3:0] pat3 [8];

      // reset state
      #12;
      expect_out("reset_state", 4'b0000, 0, 0, 2'd0, 8'd0);
      -> snap_ev;
      #3 rst = 1'b1;

      // full-rate channel, len 3
      do_cmd(4'd8, SFREQ, 8'h10);
      do_cmd(4'd8, SLEN, 8'd3);
      in = 4'b0001;
      do_cmd(4'd0, CLR, 8'd0);
      run("t1_run1", 3'b000, 4'b0001, 0, 0, 0, 0);
      run("t1_run2", 3'b000, 4'b0001, 0, 0, 0, 0);
      run("t1_run3", 3'b000, 4'b0001, 0, 0, 0, 0);
      run("t1_run4_len_end", 3'b000, 4'b0000, 0, 0, 0, 0);

      // half-rate ch1, zero-rate ch2, len 6
      do_cmd(4'd9, SFREQ, 8'h08);
      do_cmd(4'd10, SFREQ, 8'h00);
      do_cmd(4'd8, SLEN, 8'd6);
      in = 4'b0110;
      do_cmd(4'd0, CLR, 8'd0);
      pat2 = '{4'b0110, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
      for (int k = 0; k < 6; k++) run($sformatf("t2_run%0d", k+1), 3'b000, pat2[k], 0, 0, 0, 0);

      // readout spike at t=7, lowest index wins, then frozen
      do_cmd(4'd8, SLEN, 8'd15);
      do_cmd(4'd0, CLR, 8'd0);
      pat3 = '{4'b0110, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
      for (int k = 0; k < 7; k++) run($sformatf("t3_run%0d", k+1), 3'b000, pat3[k], 0, 0, 0, 0);
      run("t3_spike_t7", 3'b110, pat3[7], 1, 1, 2'd1, 8'd7);
      run("t3_frozen_a", 3'b001, 4'b0000, 1, 1, 2'd1, 8'd7);
      run("t3_frozen_b", 3'b000, 4'b0000, 1, 1, 2'd1, 8'd7);

      // timeout 5, no spikes; then spike on the timeout step
      do_cmd(4'd8, STO, 8'd5);
      in = 4'b0000;
      do_cmd(4'd0, CLR, 8'd0);
      for (int k = 0; k < 5; k++) run($sformatf("t4_run%0d", k+1), 3'b000, 4'b0000, 0, 0, 0, 0);
      run("t4_timeout", 3'b000, 4'b0000, 1, 0, 2'd0, 8'd5);
      run("t4_after_timeout", 3'b001, 4'b0000, 1, 0, 2'd0, 8'd5);
      do_cmd(4'd0, CLR, 8'd0);
      for (int k = 0; k < 5; k++) run($sformatf("t4b_run%0d", k+1), 3'b000, 4'b0000, 0, 0, 0, 0);
      run("t4b_spike_beats_timeout", 3'b001, 4'b0000, 1, 1, 2'd0, 8'd5);

      // lowering the timeout below the current t ends the run on the next RUN
      do_cmd(4'd8, STO, 8'd20);
      do_cmd(4'd0, CLR, 8'd0);
      for (int k = 0; k < 4; k++) run($sformatf("t5_run%0d", k+1), 3'b000, 4'b0000, 0, 0, 0, 0);
      do_cmd(4'd8, STO, 8'd2);
      run("t5_late_timeout", 3'b000, 4'b0000, 1, 0, 2'd0, 8'd4);

      // out-of-window / wrong-channel config and neuron traffic change nothing
      do_cmd(4'd3, SFREQ, 8'hFF);
      do_cmd(4'd12, SFREQ, 8'hFF);
      do_cmd(4'd9, SLEN, 8'd1);
      do_cmd(4'd9, STO, 8'd1);
      do_cmd(4'd3, STO, 8'd1);
      do_cmd(4'd8, IDLE, 8'hFF);
      do_cmd(4'd9, 3'd6, 8'hAA);
      do_cmd(4'd8, 3'd7, 8'h55);
      in = 4'b1111;
      do_cmd(4'd0, CLR, 8'd0);
      run("t6_run1", 3'b000, 4'b1111, 0, 0, 0, 0);
      run("t6_run2", 3'b000, 4'b0001, 0, 0, 0, 0);
      run("t6_run3_timeout2", 3'b000, 4'b0011, 1, 0, 2'd0, 8'd2);

      // asynchronous reset mid-run restores config
      do_cmd(4'd8, STO, 8'd40);
      do_cmd(4'd0, CLR, 8'd0);
      run("t7_run1", 3'b000, 4'b1111, 0, 0, 0, 0);
      run("t7_run2", 3'b000, 4'b0001, 0, 0, 0, 0);
      run("t7_run3", 3'b000, 4'b0011, 0, 0, 0, 0);
      run("t7_run4", 3'b000, 4'b0001, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      expect_out("t7_async_reset", 4'b0000, 0, 0, 2'd0, 8'd0);
      -> snap_ev;
      #3 rst = 1'b1;
      do_cmd(4'd0, CLR, 8'd0);
      for (int k = 1; k <= 36; k++)
         run($sformatf("t7_post_reset_run%0d", k), 3'b000, (k == 1) ? 4'b1111 : 4'b0000,
             (k == 36), 1'b0, 2'd0, (k == 36) ? 8'd35 : 8'd0);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expectations: got %0d unconsumed, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
